bht_controller: RTL and testbench

Controller for a branch history table (BHT) of 2-bit saturating counters, indexed by a fetch-side lookup port and a resolve-side update port. Counter storage is single-ported: each cycle it performs at most one read or one write. The block arbitrates that port between fetch lookups and the read-modify-write (RMW) sequence of buffered updates. After reset it sequences a clear of the whole table. Sits between the fetch stage (predictions) and the execute stage (resolved outcomes).

---
 rtl/bht_controller.sv | 167 ++++++++++++++++
 tb/tb_bht_controller.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/bht_controller.sv
// Branch history table controller: 2-bit saturating counters behind a
// single-ported store shared by fetch lookups and a one-entry update buffer
// that drains through a read-modify-write sequence.
// Optional build macro BHT_STATS_EN adds update / mispredict counters.
module bht_controller #(
   parameter int         IDX_W      = 6,
   parameter logic [1:0] INIT_VAL   = 2'b01,
   parameter int         STARVE_MAX = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_lkp_valid,
   output logic             o_lkp_ready,
   input  logic [IDX_W-1:0] i_lkp_idx,
   output logic             o_pred_valid,
   output logic             o_pred_taken,
   output logic             o_pred_strong,
   input  logic             i_upd_valid,
   output logic             o_upd_ready,
   input  logic [IDX_W-1:0] i_upd_idx,
   input  logic             i_upd_taken,
   input  logic             i_upd_pred,
`ifdef BHT_STATS_EN
   output logic [15:0]      o_upd_cnt,
   output logic [15:0]      o_mispred_cnt,
`endif
   output logic             o_init_done
);

   typedef enum logic [1:0] {S_INIT, S_IDLE, S_UPD_RD, S_UPD_WR} state_t;

   localparam int         DEPTH = 1 << IDX_W;
   localparam logic [3:0] SMAX  = 4'(STARVE_MAX);

   logic [1:0]       mem [DEPTH];
   state_t           state;
   logic [IDX_W-1:0] init_ptr;
   logic             buf_full;
   logic [IDX_W-1:0] buf_idx;
   logic             buf_taken;
   logic [3:0]       starve;
   logic [1:0]       rd_q;

   logic             starve_hit, lkp_fire, upd_fire, upd_go, mem_we;
   logic [IDX_W-1:0] mem_addr;
   logic [1:0]       mem_wdata, rd_data, next_cnt;

   // readiness depends only on registered state, never on the valids
   assign starve_hit  = buf_full && (starve == SMAX);
   assign o_lkp_ready = (state == S_IDLE) && !starve_hit;
   assign o_upd_ready = (state != S_INIT) && !buf_full;
   assign lkp_fire    = i_lkp_valid && o_lkp_ready;
   assign upd_fire    = i_upd_valid && o_upd_ready;
   assign upd_go      = (state == S_IDLE) && buf_full && (!i_lkp_valid || starve == SMAX);

   // single storage port: init sweep, lookup in IDLE, buffered index otherwise
   always_comb begin
      mem_addr  = buf_idx;
      mem_we    = 1'b0;
      mem_wdata = next_cnt;
      if (state == S_INIT) begin
         mem_addr  = init_ptr;
         mem_we    = 1'b1;
         mem_wdata = INIT_VAL;
      end else if (state == S_IDLE) begin
         mem_addr = i_lkp_idx;
      end else if (state == S_UPD_WR) begin
         mem_we = 1'b1;
      end
   end

   assign rd_data = mem[mem_addr];

   // saturating counter step for the buffered outcome
   always_comb begin
      next_cnt = rd_q;
      if (buf_taken) begin
         if (rd_q != 2'b11) next_cnt = rd_q + 2'b01;
      end else begin
         if (rd_q != 2'b00) next_cnt = rd_q - 2'b01;
      end
   end

   // counter storage; no reset, the init sweep defines its contents
   always_ff @(posedge i_clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
   end

   // control FSM, update buffer, starvation counter and prediction outputs
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state         <= S_INIT;
         init_ptr      <= '0;
         o_init_done   <= 1'b0;
         buf_full      <= 1'b0;
         buf_idx       <= '0;
         buf_taken     <= 1'b0;
         starve        <= '0;
         rd_q          <= '0;
         o_pred_valid  <= 1'b0;
         o_pred_taken  <= 1'b0;
         o_pred_strong <= 1'b0;
      end else begin
         case (state)
            S_INIT: begin
               init_ptr <= init_ptr + 1'b1;
               if (init_ptr == {IDX_W{1'b1}}) begin
                  state       <= S_IDLE;
                  o_init_done <= 1'b1;
               end
            end
            S_IDLE:   if (upd_go) state <= S_UPD_RD;
            S_UPD_RD: begin
               rd_q  <= rd_data;
               state <= S_UPD_WR;
            end
            S_UPD_WR: state <= S_IDLE;
            default:  state <= S_INIT;
         endcase

         if (upd_fire) begin
            buf_full  <= 1'b1;
            buf_idx   <= i_upd_idx;
            buf_taken <= i_upd_taken;
         end else if (state == S_UPD_WR) begin
            buf_full <= 1'b0;
         end

         if (upd_go)
            starve <= '0;
         else if (buf_full && lkp_fire && starve != SMAX)
            starve <= starve + 4'd1;

         o_pred_valid <= lkp_fire;
         if (lkp_fire) begin
            o_pred_taken  <= rd_data[1];
            o_pred_strong <= (rd_data[1] == rd_data[0]);
         end
      end
   end

`ifdef BHT_STATS_EN
   logic buf_pred;

   // capture the prediction used, for mispredict accounting
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)      buf_pred <= 1'b0;
      else if (upd_fire) buf_pred <= i_upd_pred;
   end

   // saturating statistics, bumped when a buffered update is written
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_upd_cnt     <= '0;
         o_mispred_cnt <= '0;
      end else if (state == S_UPD_WR) begin
         if (o_upd_cnt != 16'hFFFF) o_upd_cnt <= o_upd_cnt + 16'd1;
         if (buf_pred != buf_taken && o_mispred_cnt != 16'hFFFF)
            o_mispred_cnt <= o_mispred_cnt + 16'd1;
      end
   end
`else
   logic unused_pred;
   assign unused_pred = i_upd_pred;
`endif

endmodule

// File: tb/tb_bht_controller.sv
// Bench for bht_controller: directed scenarios plus random traffic, checked
// against a per-index counter array updated when the update buffer drains.
module tb_bht_controller;
   localparam int         IDX_W = 3;
   localparam int         SMAX  = 4;
   localparam logic [1:0] IV    = 2'b01;

   logic clk = 1'b0, rst_n = 1'b0;
   logic lkp_valid = 0, lkp_ready, pred_valid, pred_taken, pred_strong;
   logic [IDX_W-1:0] lkp_idx = '0, upd_idx = '0;
   logic upd_valid = 0, upd_ready, upd_taken = 0, upd_pred = 0, init_done;
`ifdef BHT_STATS_EN
   logic [15:0] upd_cnt, mispred_cnt;
`endif

   always #5 clk = ~clk;

   bht_controller #(.IDX_W(IDX_W), .INIT_VAL(IV), .STARVE_MAX(SMAX)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_lkp_valid(lkp_valid), .o_lkp_ready(lkp_ready), .i_lkp_idx(lkp_idx),
      .o_pred_valid(pred_valid), .o_pred_taken(pred_taken), .o_pred_strong(pred_strong),
      .i_upd_valid(upd_valid), .o_upd_ready(upd_ready), .i_upd_idx(upd_idx),
      .i_upd_taken(upd_taken), .i_upd_pred(upd_pred),
`ifdef BHT_STATS_EN
      .o_upd_cnt(upd_cnt), .o_mispred_cnt(mispred_cnt),
`endif
      .o_init_done(init_done));

   int tests = 0, fails = 0;
   int model [8];
   bit pend, p_taken, p_pred;
   int p_idx;
   bit exp_t, exp_s;
   int n_upd, n_mis;
   bit last_lready;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int bump(input int c, input bit t);
      if (t) return (c == 3) ? 3 : c + 1;
      return (c == 0) ? 0 : c - 1;
   endfunction

   // one clock: drive, note what was accepted, check the prediction after the edge
   task automatic cyc(input bit lv, input int li, input bit uv, input int ui,
                      input bit ut, input bit up);
      bit lacc, uacc;
      @(negedge clk);
      lkp_valid = lv; lkp_idx = li[IDX_W-1:0];
      upd_valid = uv; upd_idx = ui[IDX_W-1:0]; upd_taken = ut; upd_pred = up;
      #1;
      lacc = lv && lkp_ready;
      uacc = uv && upd_ready;
      last_lready = lkp_ready;
      if (lacc) begin
         exp_t = model[li] >= 2;
         exp_s = (model[li] == 0) || (model[li] == 3);
      end
      if (uacc) begin
         pend = 1; p_idx = ui; p_taken = ut; p_pred = up;
      end
      @(posedge clk); #1;
      chk("pred_valid", pred_valid, lacc);
      chk("pred_taken", pred_taken, exp_t);
      chk("pred_strong", pred_strong, exp_s);
      if (pend && upd_ready) begin
         model[p_idx] = bump(model[p_idx], p_taken);
         n_upd++;
         if (p_pred != p_taken) n_mis++;
         pend = 0;
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 10 && pend; i++) cyc(0, 0, 0, 0, 0, 0);
      chk("drain", pend, 0);
   endtask

   task automatic do_update(input int idx, input bit t, input bit p);
      cyc(0, 0, 1, idx, t, p);
      drain();
   endtask

   // assert reset at a falling edge, check outputs cleared, release and time the sweep
   task automatic do_reset();
      int cnt, busy;
      @(negedge clk);
      rst_n = 0;
      lkp_valid = 0; upd_valid = 0;
      #1;
      chk("rst_pred_valid", pred_valid, 0);
      chk("rst_pred_taken", pred_taken, 0);
      chk("rst_pred_strong", pred_strong, 0);
      chk("rst_lkp_ready", lkp_ready, 0);
      chk("rst_upd_ready", upd_ready, 0);
      chk("rst_init_done", init_done, 0);
      for (int i = 0; i < 8; i++) model[i] = IV;
      pend = 0; exp_t = 0; exp_s = 0; n_upd = 0; n_mis = 0;
      @(negedge clk); @(negedge clk);
      rst_n = 1;
      cnt = -1; busy = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (init_done) begin cnt = i; break; end
         if (lkp_ready || upd_ready) busy++;
      end
      chk("init_cycles", cnt, 8);
      chk("init_ready_low", busy, 0);
   endtask

   initial begin
      int acc, low, phase;
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      int acc, low, phase;
      do_reset();

      // every entry reads back weakly not-taken
      for (int i = 0; i < 8; i++) cyc(1, i, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      chk("hold_taken", pred_taken, 0);

      // idx 2 taken x3 -> strongly taken, 4th saturates
      for (int k = 0; k < 3; k++) do_update(2, 1, 1);
      cyc(1, 2, 0, 0, 0, 0);
      chk("idx2_taken3", pred_taken, 1);
      chk("idx2_strong3", pred_strong, 1);
      do_update(2, 1, 1);
      chk("idx2_sat_hi", model[2], 3);
      cyc(1, 2, 0, 0, 0, 0);
      for (int k = 0; k < 4; k++) do_update(2, 0, 1);
      cyc(1, 2, 0, 0, 0, 0);
      chk("idx2_nt_taken", pred_taken, 0);
      chk("idx2_nt_strong", pred_strong, 1);

      // starvation: 4 lookups win, then the arbitration-loss cycle plus RD and WR
      cyc(1, 0, 1, 3, 1, 0);
      acc = 0; low = 0; phase = 0;
      for (int i = 0; i < 20 && phase < 2; i++) begin
         cyc(1, i % 8, 0, 0, 0, 0);
         if (phase == 0) begin
            if (last_lready) acc++;
            else begin phase = 1; low = 1; end
         end else if (!last_lready) low++;
         else phase = 2;
      end
      chk("starve_acc", acc, SMAX);
      chk("starve_low", low, 3);
      chk("starve_resume", phase, 2);
      drain();

      // same-cycle lookup and update on idx 5: old value, then new
      cyc(1, 5, 1, 5, 1, 0);
      chk("idx5_old_taken", pred_taken, 0);
      chk("idx5_old_strong", pred_strong, 0);
      drain();
      cyc(1, 5, 0, 0, 0, 0);
      chk("idx5_new_taken", pred_taken, 1);
      chk("idx5_new_strong", pred_strong, 0);

      // random mixed traffic
      for (int i = 0; i < 400; i++)
         cyc($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 2) == 0,
             $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1));
      drain();
      for (int i = 0; i < 8; i++) cyc(1, i, 0, 0, 0, 0);

      // reset while in UPD_RD drops the update and reinitialises
      cyc(1, 2, 0, 0, 0, 0);
      do_update(4, 1, 1);
      do_update(4, 1, 1);
      cyc(1, 4, 0, 0, 0, 0);
      chk("pre_rst_taken", pred_taken, 1);
      cyc(0, 0, 1, 4, 1, 1);
      cyc(0, 0, 0, 0, 0, 0);
      do_reset();
      for (int i = 0; i < 8; i++) cyc(1, i, 0, 0, 0, 0);
      cyc(1, 4, 0, 0, 0, 0);
      chk("post_rst_idx4_taken", pred_taken, 0);
      chk("post_rst_idx4_strong", pred_strong, 0);

`ifdef BHT_STATS_EN
      do_update(1, 1, 0);
      do_update(1, 0, 1);
      do_update(6, 1, 0);
      do_update(6, 1, 1);
      do_update(7, 0, 0);
      chk("upd_cnt", upd_cnt, 5);
      chk("mispred_cnt", mispred_cnt, 3);
      chk("upd_cnt_model", upd_cnt, n_upd);
      chk("mispred_cnt_model", mispred_cnt, n_mis);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
